prog_lut_eval: RTL
==================

PROG_LUT_EVAL -- requirements
Module: prog_lut_eval

Interface
REQ-001 SHALL have parameter N_IN, default 3: number of boolean inputs, legal range 1..6.
REQ-002 SHALL have parameter INIT, default 8'h5B (width 2**N_IN): power-up/reset truth table, where bit i is F for input vector i.
REQ-003 SHALL use one clock and a reset that is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 in_valid  in  1  input vector offered.
REQ-007 in_vec  in  N_IN  input vector; bit N_IN-1 is the MSB (A).
REQ-008 in_ready  out  1  block accepts in_vec this cycle.
REQ-009 out_valid  out  1  out_f holds a result.
REQ-010 out_f  out  1  evaluated function value.
REQ-011 out_ready  in  1  consumer accepts out_f.
REQ-012 cfg_start  in  1  one-cycle pulse; begins or restarts a table load.
REQ-013 cfg_valid  in  1  cfg_bit is valid this cycle.
REQ-014 cfg_bit  in  1  serial truth-table bit, sent LSB (index 0) first.
REQ-015 cfg_busy  out  1  high in LOAD and COMMIT.
REQ-016 cfg_done  out  1  one-cycle pulse when a new table becomes active.

Function
REQ-017 SHALL hold an active table (2**N_IN bits) and a shadow table (2**N_IN bits).
REQ-018 Evaluation SHALL register out_f = active[in_vec] on an accepted transfer (in_valid && in_ready), with a latency of 1 cycle to out_valid.
REQ-019 in_ready SHALL equal !out_valid || out_ready.
REQ-020 A stalled result (out_valid && !out_ready) SHALL hold out_f and out_valid stable.
REQ-021 Back-to-back transfers with out_ready held high SHALL sustain 1 result per cycle.
REQ-022 The config FSM SHALL have states IDLE, LOAD and COMMIT.
REQ-023 IDLE→LOAD on cfg_start; the bit counter clears to 0.
REQ-024 In LOAD, each cfg_valid SHALL write shadow[count] = cfg_bit and increment count; cfg_valid outside LOAD SHALL be ignored.
REQ-025 LOAD→COMMIT when the accepted bit has count == 2**N_IN-1.
REQ-026 COMMIT SHALL copy shadow to active, pulse cfg_done, and return to IDLE, all in one cycle.
REQ-027 cfg_start during LOAD SHALL restart the load: count goes to 0, the active table is unchanged, and no cfg_done is issued.
REQ-028 cfg_start during COMMIT SHALL be ignored.
REQ-029 cfg_start and cfg_valid in the same cycle: cfg_start wins and the bit is discarded.
REQ-030 Evaluation SHALL continue during LOAD and COMMIT using the old table; a vector accepted in the COMMIT cycle uses the old table, and one accepted the cycle after uses the new table.
REQ-031 The counter SHALL be $clog2(2**N_IN+1) bits wide and SHALL never wrap within a load.

Reset
REQ-032 rst SHALL set active = INIT, shadow = INIT, state = IDLE, count = 0, out_valid = 0, out_f = 0, cfg_busy = 0 and cfg_done = 0.
REQ-033 rst asserted mid-LOAD or mid-COMMIT SHALL abandon the load and restore INIT, not the partial table.
REQ-034 rst asserted while a result is stalled SHALL drop that result.

Structure
REQ-035 A shared package SHALL hold the state enum (IDLE/LOAD/COMMIT) and the function TBL_W(n) = 2**n.
REQ-036 The config FSM, counter and shadow register SHALL be one sub-module, lut_cfg_loader; the evaluation pipeline stays in the top module.

Verification
REQ-037 After reset with N_IN=3, send in_vec 0..7 back-to-back → out_f = 1,1,0,1,1,0,1,0, one per cycle, each 1 cycle after acceptance.
REQ-038 Load 8'hE8 (majority), sending bits LSB first → cfg_done pulses exactly once; vectors 3, 5, 6, 7 → 1 and vectors 0, 1, 2, 4 → 0.
REQ-039 Send 4 bits, then cfg_start, then 8 bits of 8'h96 → a single cfg_done; the table is XOR3 (vector 7 → 1, vector 3 → 0).
REQ-040 Hold out_ready low for 3 cycles with in_valid high → in_ready = 0 and out_f stable; on release, no result is lost or duplicated.
REQ-041 Assert rst after 5 bits of a load → active = 8'h5B, vector 2 → 0, cfg_busy = 0, no cfg_done.
REQ-042 Offer vector 1 in the COMMIT cycle of a load of 8'h00 → result 1 (old table); vector 1 on the next cycle → 0.

Source files
------------

// File: rtl/prog_lut_eval_pkg.sv
// Shared types and helpers for the programmable LUT evaluator.
package prog_lut_eval_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } cfg_state_e;

  // Truth-table width for an n-input function.
  function automatic int TBL_W(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/prog_lut_eval_if.sv
// Evaluation handshake plus serial configuration port.
interface prog_lut_eval_if #(
  parameter int N_IN = 3
) ();
  logic            in_valid;
  logic [N_IN-1:0] in_vec;
  logic            in_ready;
  logic            out_valid;
  logic            out_f;
  logic            out_ready;
  logic            cfg_start;
  logic            cfg_valid;
  logic            cfg_bit;
  logic            cfg_busy;
  logic            cfg_done;

  modport slave (
    input  in_valid, in_vec, out_ready, cfg_start, cfg_valid, cfg_bit,
    output in_ready, out_valid, out_f, cfg_busy, cfg_done
  );

  modport master (
    output in_valid, in_vec, out_ready, cfg_start, cfg_valid, cfg_bit,
    input  in_ready, out_valid, out_f, cfg_busy, cfg_done
  );
endinterface

// File: rtl/prog_lut_eval_lut_cfg_loader.sv
// Serial truth-table loader: collects bits into a shadow table and
// flags a one-cycle COMMIT once the whole table has arrived.
module lut_cfg_loader
  import prog_lut_eval_pkg::*;
#(
  parameter int                    N_IN = 3,
  parameter logic [TBL_W(N_IN)-1:0] INIT = 'h5B
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_start,
  input  logic                   cfg_valid,
  input  logic                   cfg_bit,
  output logic [TBL_W(N_IN)-1:0] shadow,
  output logic                   commit,
  output logic                   cfg_busy,
  output logic                   cfg_done
);
  localparam int TW    = TBL_W(N_IN);
  localparam int CNT_W = $clog2(TW + 1);

  cfg_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TW-1:0]    shadow_q, shadow_d;

  // Next-state: start (re)arms the load, valid bits fill the shadow table.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (cfg_start) begin
          cnt_d = '0;                       // restart; bit this cycle dropped
        end else if (cfg_valid) begin
          shadow_d[cnt_q[N_IN-1:0]] = cfg_bit;
          cnt_d = cnt_q + 1'b1;             // reaches TW on the last bit, no wrap
          if (cnt_q == CNT_W'(TW - 1)) state_d = COMMIT;
        end
      end
      COMMIT:  state_d = IDLE;              // cfg_start ignored here
      default: state_d = IDLE;
    endcase
  end

  // State, counter and shadow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= INIT;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
    end
  end

  assign shadow   = shadow_q;
  assign commit   = (state_q == COMMIT);
  assign cfg_done = commit;
  assign cfg_busy = (state_q != IDLE);
endmodule

// File: rtl/prog_lut_eval.sv
// Programmable LUT evaluator: one-stage registered lookup with a
// serially reloadable truth table swapped in atomically on commit.
module prog_lut_eval
  import prog_lut_eval_pkg::*;
#(
  parameter int                    N_IN = 3,
  parameter logic [TBL_W(N_IN)-1:0] INIT = 'h5B
) (
  input  logic            clk,
  input  logic            rst,
  prog_lut_eval_if.slave  bus
);
  localparam int TW = TBL_W(N_IN);

  logic [TW-1:0] active_q, active_d;
  logic          out_valid_q, out_valid_d;
  logic          out_f_q, out_f_d;
  logic [TW-1:0] shadow;
  logic          commit;
  logic          accept;

  lut_cfg_loader #(.N_IN(N_IN), .INIT(INIT)) u_loader (
    .clk      (clk),
    .rst      (rst),
    .cfg_start(bus.cfg_start),
    .cfg_valid(bus.cfg_valid),
    .cfg_bit  (bus.cfg_bit),
    .shadow   (shadow),
    .commit   (commit),
    .cfg_busy (bus.cfg_busy),
    .cfg_done (bus.cfg_done)
  );

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // Lookup uses the pre-commit table during the COMMIT cycle itself.
  always_comb begin
    active_d    = commit ? shadow : active_q;
    out_valid_d = out_valid_q;
    out_f_d     = out_f_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_f_d     = active_q[bus.in_vec];
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Active table and output stage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q    <= INIT;
      out_valid_q <= 1'b0;
      out_f_q     <= 1'b0;
    end else begin
      active_q    <= active_d;
      out_valid_q <= out_valid_d;
      out_f_q     <= out_f_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_f     = out_f_q;
endmodule
